lfsr_seq_ctrl: RTL

//  Command-driven sequencer for the 6-bit LFSR generator. Owns an lfsr6_core instance and

---
 rtl/lfsr_pkg.sv | 24 ++
 rtl/lfsr6_core.sv | 30 +++
 rtl/lfsr_seq_ctrl.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/lfsr_pkg.sv
// Shared types and the LFSR step function for the 6-bit sequencer.
package lfsr_pkg;

    localparam int LFSR_W = 6;

    typedef enum logic [1:0] {
        OP_LOAD  = 2'b00,
        OP_RUN   = 2'b01,
        OP_MEAS  = 2'b10,
        OP_CLEAR = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        MEAS = 2'b10
    } fsm_e;

    // Maximal-length 6-bit sequence: every nonzero state recurs after 63 steps.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        return {s[4:0], s[5] ^ s[0]};
    endfunction

endpackage

// File: rtl/lfsr6_core.sv
// 6-bit LFSR state register; a load always wins over a step in the same cycle.
module lfsr6_core
    import lfsr_pkg::*;
#(
    parameter logic [LFSR_W-1:0] RST_SEED = 6'h01
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [LFSR_W-1:0] seed,
    input  logic              step,
    output logic [LFSR_W-1:0] state
);

    logic [LFSR_W-1:0] r_state;

    // NOTE: clocked state uses non-blocking assignment so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= RST_SEED;
        end else if (load) begin
            r_state <= seed;
        end else if (step) begin
            r_state <= lfsr_next(r_state);
        end
    end

    assign state = r_state;

endmodule

// File: rtl/lfsr_seq_ctrl.sv
// Command sequencer around lfsr6_core: seed load/clear, counted valid/ready runs
// and period measurement.
module lfsr_seq_ctrl
    import lfsr_pkg::*;
#(
    parameter int                CNT_W    = 8,
    parameter logic [LFSR_W-1:0] RST_SEED = 6'h01
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [CNT_W-1:0]  cmd_arg,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [LFSR_W-1:0] out_data,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [CNT_W-1:0]  period
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    fsm_e              r_fsm;
    logic [CNT_W-1:0]  r_cnt;
    logic [LFSR_W-1:0] r_start;
    logic              r_out_valid;
    logic              r_done;
    logic              r_err;
    logic [CNT_W-1:0]  r_period;
    logic              r_rdy_en;

    logic [LFSR_W-1:0] w_state;
    logic [LFSR_W-1:0] w_next;
    logic [LFSR_W-1:0] w_arg_seed;
    logic              w_seed_zero;
    logic              w_accept;
    logic              w_fire;
    logic              w_load;
    logic [LFSR_W-1:0] w_seed;
    logic              w_step;
    op_e               w_op;

    assign w_next      = lfsr_next(w_state);
    assign w_arg_seed  = cmd_arg[LFSR_W-1:0];
    assign w_seed_zero = (w_arg_seed == '0);
    assign w_op        = op_e'(cmd_op);
    assign w_accept    = cmd_valid && cmd_ready;
    assign w_fire      = r_out_valid && out_ready;

    // NOTE: every output of this block gets a default first, so no latch is inferred.
    always_comb begin
        w_load = 1'b0;
        w_seed = RST_SEED;
        w_step = 1'b0;
        case (r_fsm)
            IDLE: begin
                if (w_accept && w_op == OP_LOAD && !w_seed_zero) begin
                    w_load = 1'b1;
                    w_seed = w_arg_seed;
                end else if (w_accept && w_op == OP_CLEAR) begin
                    w_load = 1'b1;
                end
            end
            RUN:     w_step = w_fire;
            MEAS:    w_step = 1'b1;
            default: w_step = 1'b0;
        endcase
    end

    lfsr6_core #(
        .RST_SEED (RST_SEED)
    ) u_core (
        .clk   (clk),
        .rst   (rst),
        .load  (w_load),
        .seed  (w_seed),
        .step  (w_step),
        .state (w_state)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fsm       <= IDLE;
            r_cnt       <= '0;
            r_start     <= '0;
            r_out_valid <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_period    <= '0;
            r_rdy_en    <= 1'b0;
        end else begin
            r_rdy_en <= 1'b1;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            case (r_fsm)
                IDLE: begin
                    if (w_accept) begin
                        case (w_op)
                            OP_LOAD: begin
                                r_done <= 1'b1;
                                r_err  <= w_seed_zero;
                            end
                            OP_CLEAR: begin
                                r_period <= '0;
                                r_done   <= 1'b1;
                            end
                            OP_RUN: begin
                                if (cmd_arg == '0) begin
                                    r_done <= 1'b1;
                                end else begin
                                    r_fsm       <= RUN;
                                    r_out_valid <= 1'b1;
                                    r_cnt       <= cmd_arg;
                                end
                            end
                            default: begin
                                r_start <= w_state;
                                r_cnt   <= '0;
                                r_fsm   <= MEAS;
                            end
                        endcase
                    end
                end
                RUN: begin
                    if (w_fire) begin
                        r_cnt <= r_cnt - CNT_ONE;
                        if (r_cnt == CNT_ONE) begin
                            r_out_valid <= 1'b0;
                            r_done      <= 1'b1;
                            r_fsm       <= IDLE;
                        end
                    end
                end
                MEAS: begin
                    // The state register steps this cycle; compare its next value to the start.
                    if (w_next == r_start) begin
                        r_period <= r_cnt + CNT_ONE;
                        r_done   <= 1'b1;
                        r_fsm    <= IDLE;
                    end else if (r_cnt == CNT_MAX) begin
                        r_period <= CNT_MAX;
                        r_err    <= 1'b1;
                        r_done   <= 1'b1;
                        r_fsm    <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                default: r_fsm <= IDLE;
            endcase
        end
    end

    assign cmd_ready = r_rdy_en && (r_fsm == IDLE);
    assign busy      = (r_fsm != IDLE);
    assign out_valid = r_out_valid;
    assign out_data  = w_state;
    assign done      = r_done;
    assign err       = r_err;
    assign period    = r_period;

endmodule
